// File: rtl/cva6_lsu_issue_queue.sv
// In-order load/store issue queue in front of the LSU; allows one outstanding load and one outstanding store.
// Optional LSU_ISSUE_ADDR_FENCE_EN holds a load whose address matches the outstanding store's address.
module cva6_lsu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enq_valid_i,
  input  logic [31:0]      enq_instr_i,
  input  logic             enq_is_load_i,
  output logic             enq_ready_o,
  input  logic             lsu_ready_i,
  output logic [31:0]      instr_o,
  output logic             is_load_o,
  output logic             instr_valid_o,
  input  logic             load_mem_resp_i,
  input  logic             store_mem_resp_i,
  output logic             load_pending_o,
  output logic             store_pending_o,
  output logic [CNT_W-1:0] count_o,
  output logic             err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [32:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             load_pending;
  logic             store_pending;
  logic             err;

  logic [31:0] head_instr;
  logic        head_load;
  logic        enq_fire;
  logic        issue;
  logic        fence_hold;

  assign head_instr = mem[rd_ptr][31:0];
  assign head_load  = mem[rd_ptr][32];

  assign enq_ready_o = (count != FULL);
  assign enq_fire    = enq_valid_i && enq_ready_o;

`ifdef LSU_ISSUE_ADDR_FENCE_EN
  logic [11:0] store_addr;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      store_addr <= '0;
    else if (issue && !head_load)
      store_addr <= head_instr[11:0];
  end

  assign fence_hold = head_load && store_pending && (head_instr[11:0] == store_addr);
`else
  assign fence_hold = 1'b0;
`endif

  always_comb begin
    issue = 1'b0;
    if (count != '0 && lsu_ready_i) begin
      if (head_load)
        issue = !load_pending && !fence_hold;
      else
        issue = !store_pending;
    end
  end

  assign instr_valid_o = issue;
  assign instr_o       = issue ? head_instr : 32'h0;
  assign is_load_o     = issue ? head_load : 1'b0;

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk_i) begin
    if (enq_fire)
      mem[wr_ptr] <= {enq_is_load_i, enq_instr_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq_fire, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue takes priority: a same-kind response in the issue cycle is necessarily spurious.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_pending  <= 1'b0;
      store_pending <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (issue && head_load)
        load_pending <= 1'b1;
      else if (load_mem_resp_i)
        load_pending <= 1'b0;

      if (issue && !head_load)
        store_pending <= 1'b1;
      else if (store_mem_resp_i)
        store_pending <= 1'b0;

      if ((load_mem_resp_i && !load_pending) || (store_mem_resp_i && !store_pending))
        err <= 1'b1;
    end
  end

  assign load_pending_o  = load_pending;
  assign store_pending_o = store_pending;
  assign count_o         = count;
  assign err_o           = err;

endmodule

// File: tb/tb_cva6_lsu_issue_queue.sv
// Self-checking bench for cva6_lsu_issue_queue: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_cva6_lsu_issue_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             enq_valid_i;
  logic [31:0]      enq_instr_i;
  logic             enq_is_load_i;
  logic             enq_ready_o;
  logic             lsu_ready_i;
  logic [31:0]      instr_o;
  logic             is_load_o;
  logic             instr_valid_o;
  logic             load_mem_resp_i;
  logic             store_mem_resp_i;
  logic             load_pending_o;
  logic             store_pending_o;
  logic [CNT_W-1:0] count_o;
  logic             err_o;

  cva6_lsu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .enq_valid_i(enq_valid_i), .enq_instr_i(enq_instr_i), .enq_is_load_i(enq_is_load_i),
    .enq_ready_o(enq_ready_o), .lsu_ready_i(lsu_ready_i),
    .instr_o(instr_o), .is_load_o(is_load_o), .instr_valid_o(instr_valid_o),
    .load_mem_resp_i(load_mem_resp_i), .store_mem_resp_i(store_mem_resp_i),
    .load_pending_o(load_pending_o), .store_pending_o(store_pending_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] instr; logic is_load; } op_t;

  op_t         q[$];
  bit          m_lp, m_sp, m_err;
  logic [11:0] m_addr;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_issue();
    if (q.size() == 0 || !lsu_ready_i) return 1'b0;
    if (!q[0].is_load) return !m_sp;
    if (m_lp) return 1'b0;
`ifdef LSU_ISSUE_ADDR_FENCE_EN
    if (m_sp && q[0].instr[11:0] == m_addr) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Called at posedge+1: drive, compare outputs against the model, advance model one edge.
  task automatic cycle(input bit ev, input logic [31:0] ins, input bit ld, input bit rdy,
                       input bit lr, input bit sr, input bit rst);
    bit   iss, acc;
    op_t  o;
    enq_valid_i = ev; enq_instr_i = ins; enq_is_load_i = ld; lsu_ready_i = rdy;
    load_mem_resp_i = lr; store_mem_resp_i = sr; rst_i = rst;
    #1;
    iss = model_issue();
    chk("enq_ready", 32'(enq_ready_o), 32'(q.size() != DEPTH));
    chk("instr_valid", 32'(instr_valid_o), 32'(iss));
    chk("instr", instr_o, iss ? q[0].instr : 32'h0);
    chk("is_load", 32'(is_load_o), iss ? 32'(q[0].is_load) : 32'h0);
    chk("load_pending", 32'(load_pending_o), 32'(m_lp));
    chk("store_pending", 32'(store_pending_o), 32'(m_sp));
    chk("count", 32'(count_o), 32'(q.size()));
    chk("err", 32'(err_o), 32'(m_err));
    if (rst) begin
      q.delete(); m_lp = 0; m_sp = 0; m_err = 0;
    end else begin
      acc = ev && (q.size() != DEPTH);
      if ((lr && !m_lp) || (sr && !m_sp)) m_err = 1;
      if (iss) begin
        o = q.pop_front();
        if (o.is_load) m_lp = 1;
        else begin m_sp = 1; m_addr = o.instr[11:0]; end
        if (lr && !o.is_load) m_lp = 0;
        if (sr && o.is_load)  m_sp = 0;
      end else begin
        if (lr) m_lp = 0;
        if (sr) m_sp = 0;
      end
      if (acc) begin o.instr = ins; o.is_load = ld; q.push_back(o); end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 32'h0, 0, rdy, 0, 0, 0);
  endtask

  initial begin
    bit lr, sr;
    m_addr = '0;
    rst_i = 1; enq_valid_i = 0; enq_instr_i = 0; enq_is_load_i = 0;
    lsu_ready_i = 0; load_mem_resp_i = 0; store_mem_resp_i = 0;
    @(posedge clk_i); #1;
    cycle(0, 32'h0, 0, 0, 0, 0, 1);

    // reset then idle
    idle(0);
    chk("rst_enq_ready", 32'(enq_ready_o), 32'h1);
    chk("rst_count", 32'(count_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);

    // single load, one-cycle latency
    cycle(1, 32'h0000_0cad, 1, 1, 0, 0, 0);
    chk("t1_valid", 32'(instr_valid_o), 32'h1);
    chk("t1_instr", instr_o, 32'h0000_0cad);
    chk("t1_is_load", 32'(is_load_o), 32'h1);
    idle(1);
    chk("t1_lp", 32'(load_pending_o), 32'h1);
    chk("t1_count", 32'(count_o), 32'h0);
    cycle(0, 32'h0, 0, 1, 1, 0, 0);
    chk("t1_lp_clr", 32'(load_pending_o), 32'h0);

    // load, load, store: second load and the store behind it wait for the response
    cycle(1, 32'h0000_0100, 1, 1, 0, 0, 0);
    cycle(1, 32'h0000_0104, 1, 1, 0, 0, 0);
    cycle(1, 32'h0000_0208, 0, 1, 0, 0, 0);
    chk("t2_count", 32'(count_o), 32'h2);
    chk("t2_held", 32'(instr_valid_o), 32'h0);
    idle(1);
    chk("t2_still_held", 32'(instr_valid_o), 32'h0);
    cycle(0, 32'h0, 0, 1, 1, 0, 0);
    chk("t2_ld2_valid", 32'(instr_valid_o), 32'h1);
    chk("t2_ld2_instr", instr_o, 32'h0000_0104);
    idle(1);
    chk("t2_st_valid", 32'(instr_valid_o), 32'h1);
    chk("t2_st_is_load", 32'(is_load_o), 32'h0);
    idle(1);
    cycle(0, 32'h0, 0, 1, 1, 1, 0);
    chk("t2_retired", 32'({load_pending_o, store_pending_o}), 32'h0);

    // fill past DEPTH with the LSU stalled
    for (int i = 0; i <= DEPTH; i++)
      cycle(1, 32'h0000_0300 + 32'(i), i[0], 0, 0, 0, 0);
    chk("t3_full_ready", 32'(enq_ready_o), 32'h0);
    chk("t3_full_count", 32'(count_o), 32'(DEPTH));
    cycle(1, 32'h0000_0400, 1, 1, 0, 0, 0);
    chk("t3_drop_count", 32'(count_o), 32'(DEPTH - 1));
    cycle(0, 32'h0, 0, 0, 0, 0, 1);

    // spurious store response is sticky until reset
    cycle(0, 32'h0, 0, 0, 0, 1, 0);
    chk("t4_err_set", 32'(err_o), 32'h1);
    idle(0);
    chk("t4_err_sticky", 32'(err_o), 32'h1);
    cycle(0, 32'h0, 0, 0, 0, 0, 1);
    chk("t4_err_clr", 32'(err_o), 32'h0);

`ifdef LSU_ISSUE_ADDR_FENCE_EN
    cycle(1, 32'h0000_0cad, 0, 1, 0, 0, 0);
    cycle(1, 32'h0000_0cad, 1, 1, 0, 0, 0);
    idle(1);
    chk("f_held", 32'(instr_valid_o), 32'h0);
    cycle(0, 32'h0, 0, 1, 0, 1, 0);
    chk("f_release", 32'(instr_valid_o), 32'h1);
    idle(1);
    cycle(0, 32'h0, 0, 1, 1, 0, 0);
    cycle(1, 32'h0000_0cad, 0, 1, 0, 0, 0);
    cycle(1, 32'h0000_0cae, 1, 1, 0, 0, 0);
    chk("f_other_addr", 32'(instr_valid_o), 32'h1);
    chk("f_other_sp", 32'(store_pending_o), 32'h1);
    idle(1);
    cycle(0, 32'h0, 0, 1, 1, 1, 0);
`endif

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      lr = m_lp ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      sr = m_sp ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      cycle($urandom_range(0, 9) < 6,
            {$urandom_range(0, 15) == 0 ? 20'hfffff : 20'h0, $urandom_range(0, 1) ? 12'hcad : 12'hcae},
            $urandom_range(0, 1),
            $urandom_range(0, 3) != 0,
            lr, sr,
            $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cva6_lsu_issue_queue.md
Name: cva6_lsu_issue_queue

Overview:
- Upstream neighbour of the cva6_lsu shim/model.
- Buffers load/store micro-ops coming from dispatch in an in-order FIFO.
- Issues them to the LSU one at a time as single-cycle `instr_valid` pulses.
- Tracks at most one outstanding load and one outstanding store, which are retired by `load_mem_resp`/`store_mem_resp`. This enforces the LSU's single-outstanding-per-kind rule in hardware instead of in the bench.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- enq_valid_i  in  1  dispatch offers an op.
- enq_instr_i  in  32  op payload (address in [11:0]).
- enq_is_load_i  in  1  1 = load, 0 = store.
- enq_ready_o  out  1  queue accepts the op this cycle.
- lsu_ready_i  in  1  LSU ready (ready_o of the shim).
- instr_o  out  32  head payload; 0 when not issuing.
- is_load_o  out  1  head kind; 0 when not issuing.
- instr_valid_o  out  1  issue pulse to the LSU.
- load_mem_resp_i  in  1  load completion.
- store_mem_resp_i  in  1  store completion.
- load_pending_o  out  1  a load is outstanding.
- store_pending_o  out  1  a store is outstanding.
- count_o  out  CNT_W  FIFO occupancy.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset, sampled on posedge clk_i while rst_i=1:
  - FIFO pointers and count_o cleared to 0.
  - load_pending_o, store_pending_o and err_o cleared to 0.
  - All outputs 0, except enq_ready_o = 1 in the first cycle after reset.
  - Reset mid-operation discards all queued ops and all pending state. Responses that arrive later are ignored as long as rst_i=1.
- Enqueue:
  - enq_ready_o = (count_o != DEPTH). Purely a function of registered state; no combinational path from lsu_ready_i.
  - An op is written when enq_valid_i && enq_ready_o.
  - When full, the op is not accepted, even if a dequeue happens in the same cycle (no full-bypass).
- Issue condition, combinational:
  - Requires count_o != 0 and lsu_ready_i = 1.
  - A load head also requires !load_pending_o.
  - A store head also requires !store_pending_o.
  - Ordering is strict in-order: a blocked head blocks all later entries.
- Issue action, when the condition holds:
  - instr_valid_o = 1 and instr_o/is_load_o = head entry, in the same cycle.
  - The head pops at the clock edge.
  - The pending bit of the op's kind is set at that edge.
  - Issue latency from enqueue into an empty, unblocked queue is 1 cycle: the op is visible at the head on the next cycle.
- Retire:
  - load_mem_resp_i clears load_pending_o at the clock edge; store_mem_resp_i clears store_pending_o likewise.
  - Pending flags are registered, so an op of the same kind cannot issue in the response cycle; the earliest is the following cycle.
  - A response and an issue of the other kind in the same cycle are independent.
- Error: err_o is set (sticky until reset) when either of the following occurs:
  - load_mem_resp_i=1 while load_pending_o=0.
  - store_mem_resp_i=1 while store_pending_o=0.
  - A spurious response does not change any other state.
- Simultaneous enqueue and issue:
  - Count is unchanged.
  - The write and read pointers wrap modulo DEPTH.
- count_o = number of entries in the FIFO (enqueued, not yet issued).

Optional Feature:
- Macro: LSU_ISSUE_ADDR_FENCE_EN.
- Defined:
  - On every store issue, instr_o[11:0] is latched into a store-address register.
  - A load head whose instr[11:0] equals the latched address is held while store_pending_o=1, even if lsu_ready_i=1 and no load is pending.
  - The load issues in the cycle after store_mem_resp_i.
- Undefined:
  - No address register.
  - Loads are gated only by load_pending_o.

Test Plan:
- Reset then idle -> all outputs 0, enq_ready_o=1, count_o=0, err_o=0.
- Enqueue load 0x00000cad with lsu_ready_i=1:
  - Next cycle: instr_valid_o=1, instr_o=0x00000cad, is_load_o=1.
  - Then load_pending_o=1 and count_o=0.
  - Pulse load_mem_resp_i -> load_pending_o=0.
- Enqueue load, load, store:
  - First load issues.
  - Second load held (count_o=2) until load_mem_resp_i; the store behind it is also held (in-order).
  - After the response the second load issues, then the store the cycle after.
- Enqueue DEPTH+1 ops with lsu_ready_i=0:
  - enq_ready_o=0 after DEPTH ops, count_o=DEPTH, 5th op not accepted.
  - Raise lsu_ready_i with no responses outstanding -> first op issues and count drops.
- store_mem_resp_i with no store pending -> err_o=1 and stays 1; rst_i pulse -> err_o=0.
- With LSU_ISSUE_ADDR_FENCE_EN defined:
  - Store 0xcad issues, then load 0xcad is held although lsu_ready_i=1.
  - store_mem_resp_i -> load issues the next cycle.
  - A load to 0xcae issues immediately.
